// File: rtl/temp_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : temp_reader_if
// Brief    : Sensor serial bus plus decoded temperature outputs of temp_reader.
// Revision : 1.0 - initial release
// ============================================================================
interface temp_reader_if;
    logic       miso;
    logic       sclk;
    logic       cs_n;
    logic [5:0] temp;
    logic [3:0] temp_frac;
    logic       sample_valid;
    logic       fault;
    logic       busy;

    // master: the reader itself; slave: sensor and downstream consumer
    modport master (
        input  miso,
        output sclk, cs_n, temp, temp_frac, sample_valid, fault, busy
    );

    modport slave (
        output miso,
        input  sclk, cs_n, temp, temp_frac, sample_valid, fault, busy
    );
endinterface
`default_nettype wire

// File: rtl/temp_reader.sv
`default_nettype none
// ============================================================================
// Module   : temp_reader
// Brief    : Periodic 12-bit serial read of the temperature sensor, decoded
//            into an unsigned 6.4 fixed-point reading with fault flag.
// Revision : 1.0 - initial release
// ============================================================================
module temp_reader #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    temp_reader_if.master  bus
);

    localparam int          CNT_W       = $clog2(SAMPLE_PERIOD);
    localparam [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(SAMPLE_PERIOD - 1);
    localparam [7:0]        C_DIV_LAST  = 8'(CLK_DIV - 1);
    localparam [3:0]        C_BIT_LAST  = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]      div_q, div_d;
    logic            phase_q, phase_d;
    logic [3:0]      bit_q, bit_d;
    logic [11:0]     shreg_q, shreg_d;
    logic            miso_meta_q, miso_sync_q;
    logic [5:0]      temp_q, temp_d;
    logic [3:0]      frac_q, frac_d;
    logic            fault_q, fault_d;
    logic            valid_q, valid_d;
    logic            w_tick;

    assign w_tick = (cnt_q == C_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
            state_q     <= S_IDLE;
            div_q       <= '0;
            phase_q     <= 1'b0;
            bit_q       <= '0;
            shreg_q     <= '0;
            temp_q      <= '0;
            frac_q      <= '0;
            fault_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            cnt_q       <= w_tick ? '0 : cnt_q + CNT_W'(1);
            miso_meta_q <= bus.miso;
            miso_sync_q <= miso_meta_q;
            state_q     <= state_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            temp_q      <= temp_d;
            frac_q      <= frac_d;
            fault_q     <= fault_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        temp_d  = temp_q;
        frac_d  = frac_q;
        fault_d = fault_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_tick) begin
                    state_d = S_SETUP;
                    div_d   = '0;
                end
            end
            S_SETUP: begin
                if (div_q == C_DIV_LAST) begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_SHIFT: begin
                if (div_q != C_DIV_LAST) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = '0;
                    // Sample on the edge that raises sclk, i.e. end of the low phase
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        shreg_d = {shreg_q[10:0], miso_sync_q};
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == C_BIT_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (shreg_q[10]) begin
                    fault_d = 1'b1;
                end else begin
                    fault_d = 1'b0;
                    valid_d = 1'b1;
                    // Negative readings clamp to zero
                    temp_d  = shreg_q[11] ? 6'd0 : shreg_q[9:4];
                    frac_d  = shreg_q[11] ? 4'd0 : shreg_q[3:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cs_n         = !((state_q == S_SETUP) || (state_q == S_SHIFT));
    assign bus.sclk         = (state_q == S_SHIFT) && phase_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.temp         = temp_q;
    assign bus.temp_frac    = frac_q;
    assign bus.fault        = fault_q;
    assign bus.sample_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_temp_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_temp_reader
// Brief    : Directed self-checking bench for temp_reader with a serial sensor model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_temp_reader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    temp_reader_if bus   ();
    temp_reader_if bus_p ();

    temp_reader u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    temp_reader #(.CLK_DIV(4), .SAMPLE_PERIOD(102)) u_dut_p (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_p.master)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Sensor model: MSB presented at cs_n fall, next bit after each sclk fall
    logic [11:0] tb_frame  = 12'h000;
    logic        sens_miso = 1'b1;
    int          idx       = 11;
    bit          in_frame  = 1'b0;

    always @(negedge bus.cs_n or posedge bus.cs_n or negedge bus.sclk) begin
        if (bus.cs_n !== 1'b0) begin
            in_frame  = 1'b0;
            idx       = 11;
            sens_miso = 1'b1;
        end else begin
            if (!in_frame) begin
                in_frame = 1'b1;
                idx      = 11;
            end else begin
                idx--;
            end
            sens_miso = (idx >= 0) ? tb_frame[idx] : 1'b0;
        end
    end

    assign bus.miso   = sens_miso;
    assign bus_p.miso = 1'b0;

    int   cyc        = 0;
    int   pre_valid  = 0;
    int   p_last     = -1;
    int   p_falls    = 0;
    int   p_gap_err  = 0;
    int   p_busy_err = 0;
    logic p_prev_cs  = 1'b1;
    logic p_prev_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock, sampled on the falling edge; also tracks the short-period instance
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.sample_valid === 1'b1) pre_valid++;
        if (!rst_n) begin
            p_last      = -1;
            p_prev_cs   = 1'b1;
            p_prev_busy = 1'b0;
        end else begin
            if (p_prev_cs && (bus_p.cs_n === 1'b0)) begin
                if (p_prev_busy !== 1'b0) p_busy_err++;
                if (p_last >= 0 && (cyc - p_last) != 102) p_gap_err++;
                p_last = cyc;
                p_falls++;
            end
            p_prev_cs   = bus_p.cs_n;
            p_prev_busy = bus_p.busy;
        end
    endtask

    task automatic wait_cs_fall(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.cs_n !== 1'b0 && n < 3000);
    endtask

    task automatic run_frame(input string tag, input logic [11:0] f, input logic exp_valid,
                             input logic [5:0] et, input logic [3:0] ef, input logic efault,
                             input int exp_gap);
        int   n;
        int   vcount;
        int   vfirst;
        int   sclk_err;
        int   cs_valid_err;
        logic exp_s;
        logic done_cs;
        logic done_busy;
        tb_frame  = f;
        pre_valid = 0;
        wait_cs_fall(n);
        check({tag, "_start_gap"}, n, exp_gap);
        check({tag, "_no_early_valid"}, pre_valid, 0);
        vcount       = 0;
        vfirst       = -1;
        sclk_err     = 0;
        cs_valid_err = 0;
        done_cs      = 1'b0;
        done_busy    = 1'b0;
        for (int i = 1; i <= 103; i++) begin
            step();
            exp_s = (i >= 4 && i <= 99) ? (((i - 4) / 4) % 2 == 1) : 1'b0;
            if (bus.sclk !== exp_s) sclk_err++;
            if (i == 100) begin
                done_cs   = bus.cs_n;
                done_busy = bus.busy;
            end
            if (bus.sample_valid === 1'b1) begin
                vcount++;
                if (vfirst < 0) vfirst = i;
                if (bus.cs_n !== 1'b1) cs_valid_err++;
            end
        end
        check({tag, "_sclk_pattern_errs"}, sclk_err, 0);
        check({tag, "_done_cs_n"}, done_cs, 1);
        check({tag, "_done_busy"}, done_busy, 1);
        check({tag, "_valid_count"}, vcount, exp_valid ? 1 : 0);
        check({tag, "_valid_while_cs_low"}, cs_valid_err, 0);
        if (exp_valid) check({tag, "_valid_latency"}, vfirst, 101);
        check({tag, "_temp"}, bus.temp, et);
        check({tag, "_temp_frac"}, bus.temp_frac, ef);
        check({tag, "_fault"}, bus.fault, efault);
    endtask

    initial begin
        int n;
        int rises;
        logic prev_s;

        rst_n = 1'b0;
        repeat (3) step();
        check("rst_cs_n", bus.cs_n, 1);
        check("rst_sclk", bus.sclk, 0);
        check("rst_temp", bus.temp, 0);
        check("rst_temp_frac", bus.temp_frac, 0);
        check("rst_fault", bus.fault, 0);
        check("rst_valid", bus.sample_valid, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;

        run_frame("normal",   12'h2A8, 1'b1, 6'd42, 4'd8, 1'b0, 1000);
        run_frame("fault",    12'h7FF, 1'b0, 6'd42, 4'd8, 1'b1, 897);
        run_frame("recover",  12'h320, 1'b1, 6'd50, 4'd0, 1'b0, 897);
        run_frame("negclamp", 12'h8F0, 1'b1, 6'd0,  4'd0, 1'b0, 897);
        run_frame("reload",   12'h2A8, 1'b1, 6'd42, 4'd8, 1'b0, 897);

        // Abort a read after the 6th sclk rise
        tb_frame = 12'h320;
        wait_cs_fall(n);
        check("mid_start_gap", n, 897);
        rises  = 0;
        prev_s = 1'b0;
        for (int i = 0; i < 200 && rises < 6; i++) begin
            step();
            if (bus.sclk === 1'b1 && prev_s === 1'b0) rises++;
            prev_s = bus.sclk;
        end
        check("mid_rises_seen", rises, 6);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs_n", bus.cs_n, 1);
        check("mid_rst_sclk", bus.sclk, 0);
        check("mid_rst_temp", bus.temp, 0);
        check("mid_rst_temp_frac", bus.temp_frac, 0);
        check("mid_rst_fault", bus.fault, 0);
        check("mid_rst_valid", bus.sample_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        repeat (3) step();
        rst_n = 1'b1;

        run_frame("post_rst", 12'h320, 1'b1, 6'd50, 4'd0, 1'b0, 1000);

        check("p_enough_falls", (p_falls >= 5) ? 1 : 0, 1);
        check("p_gap_errs", p_gap_err, 0);
        check("p_busy_before_tick_errs", p_busy_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/temp_reader.md
# temp_reader

Serial front end for the off-chip digital temperature sensor. Every `SAMPLE_PERIOD` clocks it runs one 12-bit SPI-style read (`cs_n`/`sclk`/`miso`) and decodes the frame. It then presents an unsigned 6.4 fixed-point reading on `temp`/`temp_frac` with a one-cycle `sample_valid` strobe. It sits directly upstream of the temperature monitor/classifier and drives its `temp` and `temp_frac` inputs.

## Interface
- `CLK_DIV`, default 4: `sclk` half-period in `clk` cycles; legal range 3..255.
- `SAMPLE_PERIOD`, default 1000: clocks between transaction starts; must exceed `25*CLK_DIV+1`.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `miso`  input  1  sensor serial data; asynchronous to `clk`.
- `sclk`  output  1  serial clock to sensor; idles low.
- `cs_n`  output  1  sensor chip select, active-low.
- `temp`  output  6  integer degrees of last good sample.
- `temp_frac`  output  4  1/16-degree fraction of last good sample.
- `sample_valid`  output  1  one-cycle pulse when `temp`/`temp_frac` update.
- `fault`  output  1  last frame reported sensor fault.
- `busy`  output  1  transaction in progress, i.e. `cs_n` low or DONE.

## Operation
- `miso` passes through a 2-flop synchronizer. All sampling uses the synchronized copy.
- The period counter is 0..`SAMPLE_PERIOD`-1 and free-runs from reset release. A start tick fires when it wraps to 0. A tick that arrives while `busy` is ignored.
- FSM states and transitions:
  - IDLE: `cs_n`=1, `sclk`=0. Moves to SETUP on the start tick.
  - SETUP: `cs_n`=0 for `CLK_DIV` cycles, then moves to SHIFT.
  - SHIFT: 12 bits, MSB first. Each bit is `sclk` low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
    - `miso_sync` is shifted in on the clk edge where `sclk` rises.
    - After the 12th high phase, `sclk` returns low and the FSM moves to DONE.
  - DONE: `cs_n`=1, one cycle. Decodes the frame, then returns to IDLE.
- Frame format: bit 11 = sign, bit 10 = sensor fault, bits 9:4 = integer, bits 3:0 = fraction.
- Decode rules, evaluated in this priority order:
  - bit10=1: `temp`/`temp_frac` hold, `fault`=1, no `sample_valid`.
  - bit11=1: `temp`=0, `temp_frac`=0 (negative readings clamp to zero), `fault`=0, `sample_valid` pulses.
  - Otherwise: `temp`=frame[9:4], `temp_frac`=frame[3:0], `fault`=0, `sample_valid` pulses.
- `fault` is sticky until the next frame with bit10=0.
- No arithmetic beyond field extraction. The output is always in 0..63.9375, so no saturation is needed on the high side.

## Timing
- Reset values: `sclk`=0, `cs_n`=1, `temp`=0, `temp_frac`=0, `sample_valid`=0, `fault`=0, `busy`=0. The FSM is in IDLE and the counter is 0.
- First start tick occurs `SAMPLE_PERIOD` cycles after `rst_n` deasserts.
- Transaction length: `CLK_DIV` (SETUP) + `24*CLK_DIV` (SHIFT) + 1 (DONE). This is 101 cycles at default.
- `cs_n` falls one cycle after the start tick.
- The first `sclk` rise is `2*CLK_DIV` cycles after `cs_n` falls.
- `cs_n` rises in the DONE cycle.
- Outputs update on the clk edge that ends DONE:
  - `temp`, `temp_frac`, `fault` and `sample_valid` all change on that same edge.
  - `sample_valid` is high for exactly one cycle.
- `busy` is high from the `cs_n` fall through the DONE cycle inclusive.
- Input timing: the sensor changes `miso` on `sclk` falling edges. With `CLK_DIV`>=3 the synchronized data is stable at the sampling edge, so the 2-cycle synchronizer latency is absorbed.
- Reset mid-transaction:
  - All outputs return to reset values immediately (asynchronous). `cs_n` goes high at once and the partial frame is discarded.
  - The counter restarts, so the next start tick is a full `SAMPLE_PERIOD` after release.
- `sample_valid` never asserts while `cs_n` is low.

## Test plan
- Reset: hold `rst_n`=0 with `miso`=1.
  - Expect `cs_n`=1, `sclk`=0, `temp`=0, `temp_frac`=0, `fault`=0, `sample_valid`=0.
  - Expect `cs_n` to fall exactly 1000 cycles after release.
- Normal read: sensor model returns 0x2A8.
  - Expect `temp`=42, `temp_frac`=8, one `sample_valid` pulse 101 cycles after `cs_n` falls, `fault`=0.
  - Expect 12 `sclk` pulses, each 4 low / 4 high.
- Fault frame: 0x2A8 read, then 0x7FF.
  - Expect `temp`=42 and `temp_frac`=8 held, `fault`=1, no `sample_valid`.
  - A following frame of 0x320 gives `temp`=50, `temp_frac`=0, `fault`=0, with a valid pulse.
- Negative clamp: frame 0x8F0.
  - Expect `temp`=0, `temp_frac`=0, `sample_valid` pulse, `fault`=0.
- Reset mid-transaction: assert `rst_n`=0 after the 6th `sclk` rise.
  - Expect `cs_n`=1 and `sclk`=0 the same cycle, with outputs at reset values.
  - After release, expect no `sample_valid` until a full fresh transaction completes.
- Period and overlap: set `SAMPLE_PERIOD`=102 and `CLK_DIV`=4.
  - Expect `cs_n` falling edges exactly 102 cycles apart.
  - Expect `busy` to deassert before every start tick.
